// File: rtl/decim_ctrl.sv
// decim_ctrl: keep-one-in-M sample decimator with a single-entry output
// register, valid/ready handshake, IDLE/RUN/DRAIN control and a sticky
// overflow flag for dropped samples.
// Optional: define DECIM_OVF_COUNT_EN to add a saturating 16-bit ovf_count.
module decim_ctrl #(
  parameter int N    = 16,
  parameter int MMAX = 16,
  parameter int LOGM = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [LOGM:0]   ratio,
  input  logic            in_valid,
  input  logic [N-1:0]    in_sample,
  input  logic            out_ready,
  input  logic            clr_ovf,
  output logic            out_valid,
  output logic [N-1:0]    out_sample,
  output logic [LOGM-1:0] phase,
  output logic            busy,
`ifdef DECIM_OVF_COUNT_EN
  output logic [15:0]     ovf_count,
`endif
  output logic            overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [LOGM:0]   m_eff_q, m_eff_d;
  logic [LOGM-1:0] phase_q, phase_d;
  logic            vld_q, vld_d;
  logic [N-1:0]    smp_q, smp_d;
  logic            ovf_q, ovf_d;
  logic            xfer;
  logic            drop;

  assign xfer = vld_q & out_ready;

  // Next-state: control FSM, phase counter, output register and drop detect
  always_comb begin
    state_d = state_q;
    m_eff_d = m_eff_q;
    phase_d = phase_q;
    smp_d   = smp_q;
    drop    = 1'b0;
    // A delivered sample leaves the register unless refilled below
    vld_d   = vld_q & ~xfer;
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (enable) begin
          state_d = S_RUN;
          if (ratio == '0)
            m_eff_d = (LOGM+1)'(1);
          else if (int'(ratio) > MMAX)
            m_eff_d = (LOGM+1)'(MMAX);
          else
            m_eff_d = ratio;
        end
      end
      S_RUN: begin
        if (!enable) begin
          // Leaving RUN: in_valid is ignored this cycle
          if (vld_q && !xfer) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_IDLE;
            phase_d = '0;
          end
        end else if (in_valid) begin
          if ({1'b0, phase_q} == m_eff_q - 1'b1)
            phase_d = '0;
          else
            phase_d = phase_q + 1'b1;
          if (phase_q == '0) begin
            if (!vld_q || xfer) begin
              smp_d = in_sample;
              vld_d = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        // Phase holds until the pending sample is taken
        if (xfer) begin
          state_d = S_IDLE;
          phase_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase
    // A new drop wins over a simultaneous clear
    ovf_d = (ovf_q & ~clr_ovf) | drop;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_eff_q <= (LOGM+1)'(1);
      phase_q <= '0;
      vld_q   <= 1'b0;
      smp_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_eff_q <= m_eff_d;
      phase_q <= phase_d;
      vld_q   <= vld_d;
      smp_q   <= smp_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef DECIM_OVF_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Dropped-sample counter, saturating; a drop alongside a clear counts as 1
  always_comb begin
    cnt_d = cnt_q;
    if (clr_ovf)
      cnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign ovf_count = cnt_q;
`endif

  assign out_valid  = vld_q;
  assign out_sample = smp_q;
  assign phase      = phase_q;
  assign busy       = (state_q != S_IDLE);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_decim_ctrl.sv
// Directed bench for decim_ctrl: reset, ratio saturation, overflow,
// back-to-back handshake, drain and asynchronous reset mid-run.
module tb_decim_ctrl;
  localparam int N = 16, MMAX = 16, LOGM = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [LOGM:0]   ratio;
  logic            in_valid;
  logic [N-1:0]    in_sample;
  logic            out_ready;
  logic            clr_ovf;
  logic            out_valid;
  logic [N-1:0]    out_sample;
  logic [LOGM-1:0] phase;
  logic            busy;
  logic            overflow;
`ifdef DECIM_OVF_COUNT_EN
  logic [15:0]     ovf_count;
`endif

  int checks = 0;
  int errors = 0;

  decim_ctrl #(.N(N), .MMAX(MMAX), .LOGM(LOGM)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ratio(ratio),
    .in_valid(in_valid), .in_sample(in_sample), .out_ready(out_ready),
    .clr_ovf(clr_ovf), .out_valid(out_valid), .out_sample(out_sample),
    .phase(phase), .busy(busy),
`ifdef DECIM_OVF_COUNT_EN
    .ovf_count(ovf_count),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; ratio = '0; in_valid = 1'b0;
    in_sample = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sample !== 16'd0 || phase !== 4'd0 ||
        busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: vld=%b smp=%0d ph=%0d busy=%b ovf=%b, want all 0",
               out_valid, out_sample, phase, busy, overflow);
    end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  // Start from IDLE with the given ratio; one edge to enter RUN
  task automatic start(input logic [LOGM:0] r, input logic rdy);
    ratio = r; enable = 1'b1; out_ready = rdy; in_valid = 1'b0;
    step();
    ratio = 5'd7;  // must be ignored once running
    checks++;
    if (busy !== 1'b1 || phase !== 4'd0) begin
      errors++;
      $display("FAIL start: busy=%b ph=%0d, want 1/0", busy, phase);
    end
  endtask

  // Drop enable with out_ready=1: go to IDLE
  task automatic stop(input string nm);
    enable = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || phase !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_stop: busy=%b ph=%0d vld=%b, want 0/0/0", nm, busy, phase, out_valid);
    end
  endtask

  task automatic test_ratio4();
    start(5'd4, 1'b1);
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_sample = 16'(i);
      step();
      checks++;
      if (out_valid !== (i % 4 == 0) || phase !== 4'((i + 1) % 4) ||
          ((i % 4 == 0) && out_sample !== 16'(i))) begin
        errors++;
        $display("FAIL ratio4[%0d]: vld=%b ph=%0d smp=%0d, want vld=%b ph=%0d smp=%0d",
                 i, out_valid, phase, out_sample, (i % 4 == 0), (i + 1) % 4, i);
      end
    end
    stop("ratio4");
  endtask

  task automatic test_ratio_sat();
    // ratio=0 -> every sample
    start(5'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sample = 16'(100 + i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_sample !== 16'(100 + i) || phase !== 4'd0) begin
        errors++;
        $display("FAIL ratio0[%0d]: vld=%b smp=%0d ph=%0d, want 1/%0d/0",
                 i, out_valid, out_sample, phase, 100 + i);
      end
    end
    stop("ratio0");
    // ratio=31 -> clamps to 16
    start(5'd31, 1'b1);
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_sample = 16'(i);
      step();
      if (i % 16 == 0 || i % 16 == 1) begin
        checks++;
        if (out_valid !== (i % 16 == 0) || phase !== 4'((i + 1) % 16) ||
            ((i % 16 == 0) && out_sample !== 16'(i))) begin
          errors++;
          $display("FAIL ratio31[%0d]: vld=%b ph=%0d smp=%0d, want vld=%b ph=%0d smp=%0d",
                   i, out_valid, phase, out_sample, (i % 16 == 0), (i + 1) % 16, i);
        end
      end
    end
    stop("ratio31");
  endtask

  task automatic test_overflow();
    start(5'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sample = 16'(10 + i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_sample !== 16'd10 || overflow !== (i >= 2)) begin
        errors++;
        $display("FAIL ovf[%0d]: vld=%b smp=%0d ovf=%b, want 1/10/%b",
                 i, out_valid, out_sample, overflow, (i >= 2));
      end
    end
`ifdef DECIM_OVF_COUNT_EN
    checks++;
    if (ovf_count !== 16'd1) begin
      errors++;
      $display("FAIL ovf_count: got %0d want 1", ovf_count);
    end
`endif
    in_valid = 1'b0; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b vld=%b, want 0/1", overflow, out_valid);
    end
    stop("ovf");
  endtask

  task automatic test_back_to_back();
    start(5'd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sample = 16'(30 + i);
      out_ready = (i % 2 == 0);  // pulse exactly on capture cycles
      step();
      checks++;
      if (out_valid !== 1'b1 || overflow !== 1'b0 ||
          out_sample !== 16'(30 + 2 * (i / 2))) begin
        errors++;
        $display("FAIL b2b[%0d]: vld=%b ovf=%b smp=%0d, want 1/0/%0d",
                 i, out_valid, overflow, out_sample, 30 + 2 * (i / 2));
      end
    end
    stop("b2b");
  endtask

  task automatic test_drain();
    start(5'd4, 1'b0);
    in_valid = 1'b1; in_sample = 16'd20; step();
    in_sample = 16'd21; step();
    enable = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1 || phase !== 4'd2 || out_valid !== 1'b1 || out_sample !== 16'd20) begin
      errors++;
      $display("FAIL drain_enter: busy=%b ph=%0d vld=%b smp=%0d, want 1/2/1/20",
               busy, phase, out_valid, out_sample);
    end
    // enable and input while draining have no effect
    enable = 1'b1; in_valid = 1'b1; in_sample = 16'd99;
    step();
    checks++;
    if (busy !== 1'b1 || phase !== 4'd2 || out_sample !== 16'd20 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL drain_hold: busy=%b ph=%0d smp=%0d ovf=%b, want 1/2/20/0",
               busy, phase, out_sample, overflow);
    end
    enable = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || phase !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit: busy=%b ph=%0d vld=%b, want 0/0/0", busy, phase, out_valid);
    end
  endtask

  task automatic test_async_reset();
    start(5'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sample = 16'(50 + i);
      step();
    end
    checks++;
    if (out_valid !== 1'b1 || overflow !== 1'b1 || phase !== 4'd1) begin
      errors++;
      $display("FAIL arst_pre: vld=%b ovf=%b ph=%0d, want 1/1/1", out_valid, overflow, phase);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || phase !== 4'd0 || overflow !== 1'b0 ||
        busy !== 1'b0 || out_sample !== 16'd0) begin
      errors++;
      $display("FAIL arst_now: vld=%b ph=%0d ovf=%b busy=%b smp=%0d, want 0",
               out_valid, phase, overflow, busy, out_sample);
    end
    enable = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_hold: busy=%b want 0", busy);
    end
    rst = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_resume: busy=%b vld=%b, want 1/0", busy, out_valid);
    end
    stop("arst");
  endtask

  initial begin
    test_reset();
    test_ratio4();
    test_ratio_sat();
    test_overflow();
    test_back_to_back();
    test_drain();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decim_ctrl.md
DECIM_CTRL -- requirements
Module: decim_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter MMAX, default 16, meaning maximum decimation ratio.
REQ-003 The block SHALL have parameter LOGM, default 4, meaning log2(MMAX).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-006 The block SHALL have port enable, input, 1, meaning start or continue decimation when high.
REQ-007 The block SHALL have port ratio, input, LOGM+1, meaning requested decimation ratio M.
REQ-008 The block SHALL have port in_valid, input, 1, meaning in_sample is valid this cycle; there is no backpressure on the input.
REQ-009 The block SHALL have port in_sample, input, N, meaning the input sample.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the downstream consumer accepts out_sample.
REQ-011 The block SHALL have port clr_ovf, input, 1, meaning synchronous clear of the overflow flag.
REQ-012 The block SHALL have port out_valid, output, 1, meaning out_sample holds an undelivered decimated sample.
REQ-013 The block SHALL have port out_sample, output, N, meaning the decimated sample register.
REQ-014 The block SHALL have port phase, output, LOGM, meaning the current input phase, 0..M-1.
REQ-015 The block SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-016 The block SHALL have port overflow, output, 1, meaning sticky flag set when a decimated sample was dropped.

Function
REQ-017 The block SHALL implement states IDLE, RUN and DRAIN.
REQ-018 In IDLE, phase SHALL be 0, inputs SHALL be ignored, and enable=1 SHALL move the block to RUN on the next edge while latching ratio into m_eff.
REQ-019 m_eff SHALL be 1 if ratio=0, MMAX if ratio>MMAX, and ratio otherwise; ratio changes outside IDLE SHALL be ignored.
REQ-020 In RUN, each cycle with in_valid=1 SHALL advance phase by 1, wrapping from m_eff-1 to 0; with m_eff=1, phase SHALL stay at 0.
REQ-021 In RUN, a cycle with in_valid=1 and phase=0 SHALL be a capture, and the captured in_sample SHALL appear on out_sample with out_valid=1 after the next edge (1-cycle latency).
REQ-022 Output handshake: a transfer SHALL occur when out_valid=1 and out_ready=1, and out_valid SHALL fall after the edge unless a capture occurs in the same cycle.
REQ-023 When a capture and a transfer occur in the same cycle, the new sample SHALL be loaded, out_valid SHALL remain 1, and no overflow SHALL be recorded.
REQ-024 When a capture occurs with out_valid=1 and out_ready=0, the new sample SHALL be dropped, out_sample SHALL be kept, and overflow SHALL be set.
REQ-025 overflow SHALL remain set until clr_ovf=1 or reset; if clr_ovf=1 and a new overflow occur in the same cycle, overflow SHALL be 1.
REQ-026 In RUN, enable=0 SHALL move the block to DRAIN if out_valid=1 and not transferring this cycle, and to IDLE otherwise; in_valid SHALL be ignored in that cycle.
REQ-027 In DRAIN, no captures SHALL occur and phase SHALL hold; after the pending transfer the block SHALL go to IDLE, with phase reset to 0.
REQ-028 A rising enable while in DRAIN SHALL NOT take effect until IDLE is reached.
REQ-029 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE.

Reset
REQ-030 Reset SHALL force state=IDLE, phase=0, m_eff=1, out_valid=0, out_sample=0 and overflow=0 immediately, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard any pending output, and the block SHALL resume in IDLE only after rst deasserts.

Configuration
REQ-032 With macro DECIM_OVF_COUNT_EN defined, the block SHALL add output port ovf_count, 16 bits, counting dropped samples and saturating at 16'hFFFF.
REQ-033 ovf_count SHALL be cleared by clr_ovf or reset.
REQ-034 Without DECIM_OVF_COUNT_EN, the ovf_count port and its logic SHALL be absent, and only the sticky overflow flag SHALL exist.

Verification
REQ-035 The bench SHALL cover: ratio=4, out_ready=1, continuous in_valid with samples 0,1,2,...,11 -> out_sample 0,4,8, each out_valid for 1 cycle, one cycle after capture.
REQ-036 The bench SHALL cover: ratio=0 and ratio=31 -> m_eff=1 (every sample output) and m_eff=16 (samples 0,16,32) respectively.
REQ-037 The bench SHALL cover: ratio=2, out_ready=0 for 4 inputs 10,11,12,13 -> out_sample=10 held, overflow=1, ovf_count=1 when DECIM_OVF_COUNT_EN is defined.
REQ-038 The bench SHALL cover: ratio=2, out_ready pulses exactly on each capture cycle -> no overflow, out_valid held high continuously.
REQ-039 The bench SHALL cover: enable dropped with out_valid=1 and out_ready=0 -> DRAIN with busy=1; out_ready=1 -> transfer, then IDLE, with phase=0.
REQ-040 The bench SHALL cover: rst pulsed mid-RUN between clock edges with out_valid=1 -> out_valid=0, phase=0, overflow=0 immediately.
